// File: rtl/mul_pipe_if.sv
// mul_pipe_if: issue/result handshake bundle between the issue logic, the multiplier and writeback
interface mul_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush_ex_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [1:0]       op_i;
    logic [XLEN-1:0]  op1_i;
    logic [XLEN-1:0]  op2_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    modport master (
        output flush_ex_i, in_valid_i, op_i, op1_i, op2_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, tag_o, busy_o
    );

    modport slave (
        input  flush_ex_i, in_valid_i, op_i, op1_i, op2_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, tag_o, busy_o
    );
endinterface

// File: rtl/mul_pipe.sv
// mul_pipe: pipelined MUL/MULH/MULHSU/MULHU unit with global-stall backpressure, EX flush and tag passthrough
module mul_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input logic       clk_i,
    input logic       rst_i,
    mul_pipe_if.slave bus
);
    localparam int W = 2 * XLEN;

    logic [STAGES-1:0] v;
    logic [1:0]        op_r  [STAGES];
    logic [TAG_W-1:0]  tag_r [STAGES];
    logic [XLEN:0]     a, b;
    logic [W-1:0]      ae, be, prod, last_p;
    logic              advance, accept;

    assign advance        = ~v[STAGES-1] | bus.out_ready_i;
    assign bus.in_ready_o = advance & ~bus.flush_ex_i;
    assign accept         = bus.in_valid_i & bus.in_ready_o;

    // Sign-extending the XLEN+1 operands to 2*XLEN keeps the truncated product exact with a plain multiply
    assign ae   = {{(XLEN-1){a[XLEN]}}, a};
    assign be   = {{(XLEN-1){b[XLEN]}}, b};
    assign prod = ae * be;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            v <= '0;
            a <= '0;
            b <= '0;
            for (int i = 0; i < STAGES; i++) begin
                op_r[i]  <= '0;
                tag_r[i] <= '0;
            end
        end else begin
            if (bus.flush_ex_i) v <= '0;
            else if (advance) v <= (v << 1) | STAGES'(accept);
            if (advance) begin
                a        <= {(bus.op_i != 2'b11) & bus.op1_i[XLEN-1], bus.op1_i};
                b        <= {~bus.op_i[1] & bus.op2_i[XLEN-1], bus.op2_i};
                op_r[0]  <= bus.op_i;
                tag_r[0] <= bus.tag_i;
                for (int i = 1; i < STAGES; i++) begin
                    op_r[i]  <= op_r[i-1];
                    tag_r[i] <= tag_r[i-1];
                end
            end
        end

    if (STAGES > 1) begin : g_pipe
        logic [W-1:0] p [1:STAGES-1];
        always_ff @(posedge clk_i or posedge rst_i)
            if (rst_i) begin
                for (int i = 1; i < STAGES; i++) p[i] <= '0;
            end else if (advance) begin
                p[1] <= prod;
                for (int i = 2; i < STAGES; i++) p[i] <= p[i-1];
            end
        assign last_p = p[STAGES-1];
    end else begin : g_comb
        assign last_p = prod;
    end

    assign bus.out_valid_o = v[STAGES-1];
    assign bus.busy_o      = |v;
    assign bus.tag_o       = tag_r[STAGES-1];
    assign bus.result_o    = (op_r[STAGES-1] == 2'b00) ? last_p[XLEN-1:0] : last_p[W-1:XLEN];
endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: directed and random checks of a 32-bit 3-stage and a 64-bit 1-stage multiplier against a slot model
module tb_mul_pipe;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    mul_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
    mul_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

    mul_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) u32 (.clk_i(clk), .rst_i(rst), .bus(b32.slave));
    mul_pipe #(.XLEN(64), .STAGES(1), .TAG_W(5)) u64 (.clk_i(clk), .rst_i(rst), .bus(b64.slave));

    typedef struct {
        logic        v;
        logic [63:0] r;
        logic [4:0]  t;
    } slot_t;

    slot_t       p32 [3];
    slot_t       p64;
    logic [63:0] exp64;
    logic [4:0]  delivered [$];
    logic        acc32;
    int          errs = 0, checks = 0, k;

    function automatic logic [31:0] ref32(logic [1:0] op, logic [31:0] x, logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        longint p  = (op == 2'd1) ? sx * sy : (op == 2'd2) ? sx * uy : ux * uy;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [63:0] ref64u(logic [1:0] op, logic [63:0] x, logic [63:0] y);
        logic [127:0] p = {64'b0, x} * {64'b0, y};
        return (op == 2'd0) ? p[63:0] : p[127:64];
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic clear_models();
        foreach (p32[i]) p32[i].v = 0;
        p64.v = 0;
    endtask

    // One clock: compare both DUTs with the slot model at negedge, then advance the model
    task automatic cyc();
        logic rdy, adv;
        @(negedge clk);
        rdy = (!p32[2].v | b32.out_ready_i) & !b32.flush_ex_i;
        chk("rdy32", b32.in_ready_o, rdy);
        chk("val32", b32.out_valid_o, p32[2].v);
        chk("busy32", b32.busy_o, p32[0].v | p32[1].v | p32[2].v);
        if (p32[2].v) begin
            chk("res32", b32.result_o, p32[2].r);
            chk("tag32", b32.tag_o, p32[2].t);
        end
        if (b32.out_valid_o & b32.out_ready_i) delivered.push_back(b32.tag_o);
        acc32 = b32.in_valid_i & rdy;
        adv   = !p32[2].v | b32.out_ready_i;
        if (adv) begin
            p32[2] = p32[1];
            p32[1] = p32[0];
            p32[0] = '{acc32, 64'(ref32(b32.op_i, b32.op1_i, b32.op2_i)), b32.tag_i};
        end
        if (b32.flush_ex_i) foreach (p32[i]) p32[i].v = 0;
        rdy = (!p64.v | b64.out_ready_i) & !b64.flush_ex_i;
        chk("rdy64", b64.in_ready_o, rdy);
        chk("val64", b64.out_valid_o, p64.v);
        chk("busy64", b64.busy_o, p64.v);
        if (p64.v) begin
            chk("res64", b64.result_o, p64.r);
            chk("tag64", b64.tag_o, p64.t);
        end
        if (!p64.v | b64.out_ready_i) p64 = '{b64.in_valid_i & rdy, exp64, b64.tag_i};
        if (b64.flush_ex_i) p64.v = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        b32.in_valid_i = 0;
        b64.in_valid_i = 0;
        repeat (n) cyc();
    endtask

    task automatic issue32(logic [1:0] op, logic [31:0] x, logic [31:0] y, logic [4:0] t);
        b32.in_valid_i = 1;
        b32.op_i = op;
        b32.op1_i = x;
        b32.op2_i = y;
        b32.tag_i = t;
        cyc();
    endtask

    task automatic issue64(logic [1:0] op, logic [63:0] x, logic [63:0] y, logic [4:0] t, logic [63:0] e);
        b64.in_valid_i = 1;
        b64.op_i = op;
        b64.op1_i = x;
        b64.op2_i = y;
        b64.tag_i = t;
        exp64 = e;
        cyc();
    endtask

    initial begin
        b32.flush_ex_i = 0; b32.in_valid_i = 0; b32.op_i = 0; b32.op1_i = 0; b32.op2_i = 0;
        b32.tag_i = 0; b32.out_ready_i = 1;
        b64.flush_ex_i = 0; b64.in_valid_i = 0; b64.op_i = 0; b64.op1_i = 0; b64.op2_i = 0;
        b64.tag_i = 0; b64.out_ready_i = 1; exp64 = 0;
        clear_models();
        #1;
        chk("rst_val32", b32.out_valid_o, 0);
        chk("rst_res32", b32.result_o, 0);
        chk("rst_tag32", b32.tag_o, 0);
        chk("rst_busy32", b32.busy_o, 0);
        chk("rst_res64", b64.result_o, 0);
        chk("rst_busy64", b64.busy_o, 0);
        @(posedge clk);
        #1;
        rst = 0;

        issue32(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
        issue32(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
        issue32(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
        chk("lat3_val", b32.out_valid_o, 1);
        chk("lat3_res", b32.result_o, 32'h00000001);
        issue32(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        chk("mulh_m1", b32.result_o, 32'h00000000);
        idle(1);
        chk("mulhsu_m1", b32.result_o, 32'hFFFFFFFF);
        idle(1);
        chk("mulhu_m1", b32.result_o, 32'hFFFFFFFE);
        idle(2);
        chk("order_n", delivered.size(), 4);
        foreach (delivered[i]) chk("order_tag", delivered[i], 5'(i + 1));

        issue32(2'd1, 32'h80000000, 32'h80000000, 5'd5);
        issue32(2'd0, 32'h80000000, 32'h80000000, 5'd6);
        issue32(2'd3, 32'h80000000, 32'h80000000, 5'd7);
        chk("mulh_min", b32.result_o, 32'h40000000);
        issue32(2'd2, 32'h80000000, 32'h00000002, 5'd8);
        idle(2);
        chk("mulhsu_min", b32.result_o, 32'hFFFFFFFF);
        idle(2);

        b32.out_ready_i = 0;
        delivered.delete();
        k = 0;
        for (int c = 0; c < 6; c++) begin
            if (k < 5) issue32(2'(k), 32'hDEAD0000 + 32'(k), 32'(k + 3), 5'(10 + k));
            else idle(1);
            if (acc32) k++;
        end
        chk("bp_acc", k, 3);
        chk("bp_ready", b32.in_ready_o, 0);
        chk("bp_hold_tag", b32.tag_o, 5'd10);
        chk("bp_hold_res", b32.result_o, 64'(ref32(2'd0, 32'hDEAD0000, 32'd3)));
        b32.out_ready_i = 1;
        for (int c = 0; c < 20 && k < 5; c++) begin
            issue32(2'(k), 32'hDEAD0000 + 32'(k), 32'(k + 3), 5'(10 + k));
            if (acc32) k++;
        end
        idle(6);
        chk("bp_count", delivered.size(), 5);
        foreach (delivered[i]) chk("bp_tag", delivered[i], 5'(10 + i));

        delivered.delete();
        issue32(2'd0, 32'd3, 32'd4, 5'd20);
        issue32(2'd0, 32'd5, 32'd6, 5'd21);
        issue32(2'd0, 32'd7, 32'd8, 5'd22);
        b32.flush_ex_i = 1;
        issue32(2'd0, 32'd9, 32'd9, 5'd23);
        b32.flush_ex_i = 0;
        chk("fl_val", b32.out_valid_o, 0);
        chk("fl_busy", b32.busy_o, 0);
        idle(5);
        chk("fl_count", delivered.size(), 1);
        chk("fl_tag", delivered[0], 5'd20);

        issue32(2'd0, 32'd11, 32'd12, 5'd30);
        issue32(2'd0, 32'd13, 32'd14, 5'd31);
        b32.in_valid_i = 0;
        #2;
        rst = 1;
        #1;
        chk("arst_val", b32.out_valid_o, 0);
        chk("arst_res", b32.result_o, 0);
        chk("arst_tag", b32.tag_o, 0);
        chk("arst_busy", b32.busy_o, 0);
        clear_models();
        @(posedge clk);
        #1;
        rst = 0;
        delivered.delete();
        issue32(2'd0, 32'd7, 32'd6, 5'd7);
        idle(2);
        chk("post_rst_val", b32.out_valid_o, 1);
        chk("post_rst_res", b32.result_o, 32'd42);
        chk("post_rst_tag", b32.tag_o, 5'd7);
        idle(2);
        chk("post_rst_n", delivered.size(), 1);

        for (int c = 0; c < 80; c++) begin
            b32.out_ready_i = $urandom_range(0, 3) != 0;
            b32.flush_ex_i  = $urandom_range(0, 15) == 0;
            b32.in_valid_i  = $urandom_range(0, 3) != 0;
            b32.op_i  = 2'($urandom_range(0, 3));
            b32.op1_i = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            b32.op2_i = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            b32.tag_i = 5'($urandom);
            cyc();
        end
        b32.flush_ex_i = 0;
        b32.out_ready_i = 1;
        idle(5);

        issue64(2'd3, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd1, 64'h1);
        chk("u64_val", b64.out_valid_o, 1);
        chk("u64_mulhu", b64.result_o, 64'h1);
        issue64(2'd0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd2, 64'hFFFFFFFFFFFFFFFE);
        chk("u64_mul", b64.result_o, 64'hFFFFFFFFFFFFFFFE);
        issue64(2'd2, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd3, 64'hFFFFFFFFFFFFFFFF);
        issue64(2'd1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd4, 64'h0);
        issue64(2'd1, 64'h8000000000000000, 64'h8000000000000000, 5'd5, 64'h4000000000000000);
        for (int c = 0; c < 20; c++) begin
            logic [1:0] op;
            logic [63:0] x, y;
            op = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            b64.out_ready_i = $urandom_range(0, 3) != 0;
            if (b64.in_ready_o && b64.in_valid_i) issue64(op, x, y, 5'($urandom), ref64u(op, x, y));
            else if (!b64.in_valid_i) issue64(op, x, y, 5'($urandom), ref64u(op, x, y));
            else cyc();
        end
        b64.out_ready_i = 1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
